palette_ram_ctrl: RTL

//   Owns a 64x15 custom-palette RAM shared by two requesters: the pixel lookup

---
 rtl/palette_ram_ctrl_if.sv | 38 +++
 rtl/palette_ram_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/palette_ram_ctrl_if.sv
//==============================================================================
// Module : palette_ram_ctrl_if
// Brief  : Bus bundle for the custom-palette RAM controller. Carries the pixel
//          read port and the host ioctl download port.
//          master : pixel pipeline + host loader side
//          slave  : palette_ram_ctrl side
//          Signals: rd_req/color -> pixel_out/pixel_valid (read path)
//                   ioctl_download/ioctl_wr/ioctl_dout -> ioctl_wait/pal_loaded
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface palette_ram_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              rd_req;
    logic [ADDR_W-1:0] color;
    logic [14:0]       pixel_out;
    logic              pixel_valid;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              pal_loaded;

    modport master (
        output rd_req, color, ioctl_download, ioctl_wr, ioctl_dout,
        input  pixel_out, pixel_valid, ioctl_wait, pal_loaded
    );

    modport slave (
        input  rd_req, color, ioctl_download, ioctl_wr, ioctl_dout,
        output pixel_out, pixel_valid, ioctl_wait, pal_loaded
    );
endinterface

`default_nettype wire

// File: rtl/palette_ram_ctrl.sv
//==============================================================================
// Module : palette_ram_ctrl
// Brief  : Owns the custom-palette RAM (ENTRIES x 15). Pixel reads have strict
//          priority with a fixed 1-cycle latency; host download bytes (R,G,B)
//          are packed into {B,G,R} 5-bit entries and each RAM write is deferred
//          into the first cycle without a pixel read.
// Ports  : clk    - system clock, posedge
//          reset  - asynchronous, active-high
//          bus    - palette_ram_ctrl_if.slave (read port + ioctl port)
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module palette_ram_ctrl #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 6
) (
    input  wire logic         clk,
    input  wire logic         reset,
    palette_ram_ctrl_if.slave bus
);

    localparam logic [ADDR_W:0]   c_ENTRIES = (ADDR_W+1)'(ENTRIES);
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(ENTRIES-1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_phase, w_phase_nxt;
    logic [ADDR_W:0]   r_entry, w_entry_nxt;     // one extra bit: saturates at ENTRIES
    logic              r_loaded, w_loaded_nxt;
    logic [4:0]        r_red, w_red_nxt;
    logic [4:0]        r_green, w_green_nxt;
    logic [14:0]       r_pend_data, w_pend_data_nxt;
    logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
    logic              r_restart, w_restart_nxt;  // rising edge seen while PENDING
    logic              r_dl_q;
    logic              w_mem_we;
    logic              w_dl_rise;

    logic [14:0]       r_mem [0:ENTRIES-1];
    logic [14:0]       r_pixel;
    logic              r_pixel_valid;

    // Only the top 5 bits of each download byte form a colour channel.
    logic              w_unused;
    assign w_unused = ^bus.ioctl_dout[2:0];

    assign w_dl_rise       = bus.ioctl_download & ~r_dl_q;
    assign bus.ioctl_wait  = (r_state == PENDING);
    assign bus.pal_loaded  = r_loaded;
    assign bus.pixel_out   = r_pixel;
    assign bus.pixel_valid = r_pixel_valid;

    // Read path: never stalled, so it also decides when the write may go.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= bus.rd_req;
            if (bus.rd_req) begin
                r_pixel <= r_mem[bus.color];
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_pend_addr] <= r_pend_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= 2'd0;
            r_entry     <= '0;
            r_loaded    <= 1'b0;
            r_red       <= '0;
            r_green     <= '0;
            r_pend_data <= '0;
            r_pend_addr <= '0;
            r_restart   <= 1'b0;
            r_dl_q      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_entry     <= w_entry_nxt;
            r_loaded    <= w_loaded_nxt;
            r_red       <= w_red_nxt;
            r_green     <= w_green_nxt;
            r_pend_data <= w_pend_data_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_restart   <= w_restart_nxt;
            r_dl_q      <= bus.ioctl_download;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_entry_nxt     = r_entry;
        w_loaded_nxt    = r_loaded;
        w_red_nxt       = r_red;
        w_green_nxt     = r_green;
        w_pend_data_nxt = r_pend_data;
        w_pend_addr_nxt = r_pend_addr;
        w_restart_nxt   = r_restart;
        w_mem_we        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_dl_rise) begin
                    w_state_nxt  = COLLECT;
                    w_phase_nxt  = 2'd0;
                    w_entry_nxt  = '0;
                    w_loaded_nxt = 1'b0;
                end
            end

            COLLECT: begin
                if (w_dl_rise) begin
                    w_phase_nxt  = 2'd0;
                    w_entry_nxt  = '0;
                    w_loaded_nxt = 1'b0;
                end else if (!bus.ioctl_download) begin
                    // Partial R/G bytes are simply forgotten.
                    w_state_nxt = IDLE;
                    w_phase_nxt = 2'd0;
                end else if (bus.ioctl_wr && (r_entry < c_ENTRIES)) begin
                    case (r_phase)
                        2'd0: begin
                            w_red_nxt   = bus.ioctl_dout[7:3];
                            w_phase_nxt = 2'd1;
                        end
                        2'd1: begin
                            w_green_nxt = bus.ioctl_dout[7:3];
                            w_phase_nxt = 2'd2;
                        end
                        default: begin
                            w_pend_data_nxt = {bus.ioctl_dout[7:3], r_green, r_red};
                            w_pend_addr_nxt = r_entry[ADDR_W-1:0];
                            w_phase_nxt     = 2'd0;
                            w_state_nxt     = PENDING;
                        end
                    endcase
                end
            end

            PENDING: begin
                // Host bytes are ignored here; a new download edge is remembered
                // so the restart happens only after this commit.
                if (w_dl_rise) begin
                    w_restart_nxt = 1'b1;
                end
                if (!bus.rd_req) begin
                    w_mem_we      = 1'b1;
                    w_restart_nxt = 1'b0;
                    if (r_entry < c_ENTRIES) begin
                        w_entry_nxt = r_entry + (ADDR_W+1)'(1);
                    end
                    if (r_pend_addr == c_LAST) begin
                        w_loaded_nxt = 1'b1;
                    end
                    if (!bus.ioctl_download) begin
                        w_state_nxt = IDLE;
                    end else if (r_restart || w_dl_rise) begin
                        w_state_nxt  = COLLECT;
                        w_phase_nxt  = 2'd0;
                        w_entry_nxt  = '0;
                        w_loaded_nxt = 1'b0;
                    end else begin
                        w_state_nxt = COLLECT;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
